icache_refill_unit: RTL and testbench

- Write-side master for the instruction-cache data array.
- Accepts one miss at a time and issues a block-aligned read burst to memory.
- Assembles MEM_DATA_WIDTH beats into one BLOCK_WIDTH line, then performs a single-cycle masked write into the victim way, bank and set.
- Sits between the icache miss logic and the memory/bus adapter; drives the array's refill write port directly.

---
 rtl/icache_refill_unit.sv | 180 ++++++++++++++++++
 tb/tb_icache_refill_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_unit.sv
// -----------------------------------------------------------------------------
// icache_refill_unit
//
// Purpose:
//   Write-side master for the instruction-cache data array. Takes one miss at
//   a time, issues a single block-aligned read burst, assembles the response
//   beats into a full line and writes it into the victim way / bank / set with
//   a single-cycle masked write.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i                   abort the refill in progress
//   miss_valid_i/ready_o      miss handshake
//   miss_addr_i, miss_way_i   missing address (any offset), victim way mask
//   mem_req_valid_o/ready_i   burst request handshake
//   mem_req_addr_o            block-aligned burst address
//   mem_rsp_valid_i/data_i    response beats (no backpressure)
//   mem_rsp_last_i            final beat marker from memory
//   w_bank_addr_o             set index within the bank
//   w_bank_sel_o              bank select
//   we_way_mask_o             per-way write enable (only in the write cycle)
//   wdata_o                   assembled line
//   refill_done_o             one-cycle pulse coincident with the write
//   refill_addr_o             block-aligned address of current/last refill
//   busy_o                    refill in progress
//   err_o                     sticky protocol error
// -----------------------------------------------------------------------------
module icache_refill_unit #(
    parameter int NUM_WAYS            = 4,
    parameter int NUM_BANKS           = 4,
    parameter int SETS_PER_BANK_WIDTH = 8,
    parameter int BLOCK_WIDTH         = 512,
    parameter int MEM_DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH          = 32,
    localparam int BEATS  = BLOCK_WIDTH / MEM_DATA_WIDTH,
    localparam int OFF_W  = $clog2(BLOCK_WIDTH / 8),
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           miss_valid_i,
    output logic                           miss_ready_o,
    input  logic [ADDR_WIDTH-1:0]          miss_addr_i,
    input  logic [NUM_WAYS-1:0]            miss_way_i,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
    input  logic                           mem_rsp_valid_i,
    input  logic [MEM_DATA_WIDTH-1:0]      mem_rsp_data_i,
    input  logic                           mem_rsp_last_i,
    output logic [SETS_PER_BANK_WIDTH-1:0] w_bank_addr_o,
    output logic [BANK_W-1:0]              w_bank_sel_o,
    output logic [NUM_WAYS-1:0]            we_way_mask_o,
    output logic [BLOCK_WIDTH-1:0]         wdata_o,
    output logic                           refill_done_o,
    output logic [ADDR_WIDTH-1:0]          refill_addr_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RECV,
        DRAIN,
        WRITE
    } state_t;

    state_t                         state_q;
    logic [CNT_W-1:0]               beat_cnt_q;
    logic [BLOCK_WIDTH-1:0]         line_q;
    logic                           err_q;
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [NUM_WAYS-1:0]            way_q;
    logic [BANK_W-1:0]              bank_sel_q;
    logic [SETS_PER_BANK_WIDTH-1:0] bank_addr_q;

    logic last_beat;
    logic in_rx;
    logic write_fire;

    assign last_beat  = (beat_cnt_q == LAST_BEAT);
    assign in_rx      = (state_q == RECV) || (state_q == DRAIN);
    // A flush landing on the write cycle cancels the write entirely.
    assign write_fire = (state_q == WRITE) && !flush_i;

    assign miss_ready_o    = (state_q == IDLE) && !flush_i;
    assign mem_req_valid_o = (state_q == REQ) && !flush_i;
    assign mem_req_addr_o  = addr_q;
    assign w_bank_addr_o   = bank_addr_q;
    assign w_bank_sel_o    = bank_sel_q;
    assign refill_addr_o   = addr_q;
    assign we_way_mask_o   = write_fire ? way_q : '0;
    assign refill_done_o   = write_fire;
    assign wdata_o         = line_q;
    assign busy_o          = (state_q != IDLE);
    assign err_o           = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            line_q      <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            way_q       <= '0;
            bank_sel_q  <= '0;
            bank_addr_q <= '0;
        end else begin
            // Stray beats outside a burst, and a last marker that disagrees
            // with the beat count, are both flagged; the FSM itself always
            // trusts its own count.
            if (mem_rsp_valid_i && !in_rx) begin
                err_q <= 1'b1;
            end
            if (mem_rsp_valid_i && in_rx && (last_beat != mem_rsp_last_i)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (miss_valid_i && !flush_i) begin
                        addr_q      <= miss_addr_i & ~OFF_MASK;
                        bank_sel_q  <= miss_addr_i[OFF_W +: BANK_W];
                        bank_addr_q <= miss_addr_i[OFF_W+BANK_W +: SETS_PER_BANK_WIDTH];
                        way_q       <= miss_way_i;
                        beat_cnt_q  <= '0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (mem_req_ready_i) begin
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (mem_rsp_valid_i) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_cnt_q == CNT_W'(i)) begin
                                line_q[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_rsp_data_i;
                            end
                        end
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_q <= flush_i ? IDLE : WRITE;
                        end else if (flush_i) begin
                            state_q <= DRAIN;
                        end
                    end else if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Burst cannot be cancelled at the memory side, so the
                    // remaining beats are counted off and discarded.
                    if (mem_rsp_valid_i) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_q <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_unit.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_unit
//
// Directed plus randomized refills against a reference model that works from
// plain address arithmetic (bank/set/alignment) and a per-refill beat list.
// -----------------------------------------------------------------------------
module tb_icache_refill_unit;

    localparam int BEATS = 8;
    localparam int NO    = -1;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         miss_valid_i = 1'b0;
    logic         miss_ready_o;
    logic [31:0]  miss_addr_i = '0;
    logic [3:0]   miss_way_i = '0;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic [31:0]  mem_req_addr_o;
    logic         mem_rsp_valid_i = 1'b0;
    logic [63:0]  mem_rsp_data_i = '0;
    logic         mem_rsp_last_i = 1'b0;
    logic [7:0]   w_bank_addr_o;
    logic [1:0]   w_bank_sel_o;
    logic [3:0]   we_way_mask_o;
    logic [511:0] wdata_o;
    logic         refill_done_o;
    logic [31:0]  refill_addr_o;
    logic         busy_o;
    logic         err_o;

    int checks = 0;
    int failures = 0;
    int n_writes = 0;
    int n_reqs = 0;
    int exp_writes = 0;
    int exp_reqs = 0;
    bit err_exp = 1'b0;

    icache_refill_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .miss_valid_i    (miss_valid_i),
        .miss_ready_o    (miss_ready_o),
        .miss_addr_i     (miss_addr_i),
        .miss_way_i      (miss_way_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_last_i  (mem_rsp_last_i),
        .w_bank_addr_o   (w_bank_addr_o),
        .w_bank_sel_o    (w_bank_sel_o),
        .we_way_mask_o   (we_way_mask_o),
        .wdata_o         (wdata_o),
        .refill_done_o   (refill_done_o),
        .refill_addr_o   (refill_addr_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Count every write cycle and every accepted burst request.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (refill_done_o || (we_way_mask_o != 4'b0000)) n_writes++;
            if (mem_req_valid_o && mem_req_ready_i) n_reqs++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One refill. last_idx: beat carrying the last marker. flush_at: flush in a
    // beat-free cycle before that beat (BEATS means during the write cycle).
    // rst_at: reset in a beat-free cycle before that beat, then stop.
    task automatic refill(input logic [31:0] addr, input logic [3:0] way,
                          input int grant_delay, input int gap, input int last_idx,
                          input int flush_at, input int rst_at, input bit pattern,
                          input bit hold, input logic [31:0] naddr, input logic [3:0] nway);
        logic [511:0] line;
        logic [63:0]  d;
        logic [31:0]  al;
        int           bank;
        int           set;
        int           g;
        bit           flushed;
        al      = addr - (addr % 64);
        bank    = (addr / 64) % 4;
        set     = (addr / 256) % 256;
        line    = '0;
        flushed = 1'b0;

        miss_valid_i = 1'b1;
        miss_addr_i  = addr;
        miss_way_i   = way;
        #1;
        chk("accept_ready", miss_ready_o, 1);
        tick();
        if (hold) begin
            miss_addr_i = naddr;
            miss_way_i  = nway;
        end else begin
            miss_valid_i = 1'b0;
        end

        for (int i = 0; i <= grant_delay; i++) begin
            mem_req_ready_i = (i == grant_delay);
            #1;
            chk("req_valid", mem_req_valid_o, 1);
            chk("req_addr", mem_req_addr_o, al);
            chk("busy_req", busy_o, 1);
            chk("ready_in_req", miss_ready_o, 0);
            tick();
        end
        mem_req_ready_i = 1'b0;
        exp_reqs++;

        for (int b = 0; b < BEATS; b++) begin
            if (b == rst_at) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                #1;
                chk("rst_ready", miss_ready_o, 1);
                chk("rst_busy", busy_o, 0);
                chk("rst_we", we_way_mask_o, 0);
                chk("rst_err", err_o, 0);
                chk("rst_wdata", wdata_o, 0);
                chk("rst_raddr", refill_addr_o, 0);
                err_exp = 1'b0;
                return;
            end
            if (b == flush_at) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
                flushed = 1'b1;
            end
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) tick();
            d = pattern ? (64'h1111_0000_0000_0000 | 64'(b)) : {$urandom, $urandom};
            line[b*64 +: 64] = d;
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = d;
            mem_rsp_last_i  = (b == last_idx);
            if ((b == BEATS - 1) != (b == last_idx)) err_exp = 1'b1;
            #1;
            chk("busy_recv", busy_o, 1);
            chk("we_recv", we_way_mask_o, 0);
            tick();
            mem_rsp_valid_i = 1'b0;
            mem_rsp_last_i  = 1'b0;
        end

        if (flush_at == BEATS) flush_i = 1'b1;
        #1;
        if (flush_at == BEATS) begin
            chk("wflush_we", we_way_mask_o, 0);
            chk("wflush_done", refill_done_o, 0);
        end else if (flushed) begin
            chk("flush_we", we_way_mask_o, 0);
            chk("flush_done", refill_done_o, 0);
            chk("flush_ready", miss_ready_o, 1);
            chk("flush_busy", busy_o, 0);
        end else begin
            chk("write_mask", we_way_mask_o, way);
            chk("write_done", refill_done_o, 1);
            chk("write_data", wdata_o, line);
            chk("write_bank_sel", w_bank_sel_o, bank);
            chk("write_bank_addr", w_bank_addr_o, set);
            chk("write_raddr", refill_addr_o, al);
            chk("write_busy", busy_o, 1);
            chk("write_no_accept", miss_ready_o, 0);
            exp_writes++;
        end
        tick();
        flush_i = 1'b0;
        #1;
        chk("post_we", we_way_mask_o, 0);
        chk("post_done", refill_done_o, 0);
        chk("post_ready", miss_ready_o, 1);
        chk("post_busy", busy_o, 0);
        chk("post_err", err_o, err_exp);
        chk("write_count", n_writes, exp_writes);
        chk("req_count", n_reqs, exp_reqs);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        int          r;

        // Reset state
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        #1;
        chk("reset_ready", miss_ready_o, 1);
        chk("reset_req_valid", mem_req_valid_o, 0);
        chk("reset_req_addr", mem_req_addr_o, 0);
        chk("reset_bank_addr", w_bank_addr_o, 0);
        chk("reset_bank_sel", w_bank_sel_o, 0);
        chk("reset_we", we_way_mask_o, 0);
        chk("reset_wdata", wdata_o, 0);
        chk("reset_done", refill_done_o, 0);
        chk("reset_raddr", refill_addr_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_err", err_o, 0);

        // Basic refill with the documented address split
        refill(32'h0000_12C4, 4'b0100, 0, 0, 7, NO, NO, 1'b1, 1'b0, '0, '0);
        chk("basic_bank_sel", w_bank_sel_o, 2'd3);
        chk("basic_bank_addr", w_bank_addr_o, 8'h12);
        chk("basic_lo_beat", wdata_o[63:0], 64'h1111_0000_0000_0000);
        chk("basic_hi_beat", wdata_o[511:448], 64'h1111_0000_0000_0007);

        // Delayed grant and bubbled beats
        refill($urandom, 4'b0001, 5, 1, 7, NO, NO, 1'b0, 1'b0, '0, '0);

        // Back-to-back: second miss held during the first refill
        refill(32'hABCD_0F7F, 4'b0010, 1, 0, 7, NO, NO, 1'b0, 1'b1, 32'h0000_3A41, 4'b1000);
        refill(32'h0000_3A41, 4'b1000, 0, 0, 7, NO, NO, 1'b0, 1'b0, '0, '0);
        miss_valid_i = 1'b0;

        // Flush after beat 3: drain the rest, no write
        refill($urandom, 4'b0001, 0, 0, 7, 4, NO, 1'b0, 1'b0, '0, '0);

        // Flush on the write cycle cancels the write
        refill($urandom, 4'b0010, 0, 0, 7, BEATS, NO, 1'b0, 1'b0, '0, '0);

        // Early last marker on beat 5: sticky error, write still happens
        refill($urandom, 4'b0100, 0, 0, 5, NO, NO, 1'b0, 1'b0, '0, '0);
        refill($urandom, 4'b1000, 1, 0, 7, NO, NO, 1'b0, 1'b0, '0, '0);

        // Reset after beat 2 returns to the reset state and clears the error
        refill($urandom, 4'b0001, 0, 0, 7, NO, 3, 1'b0, 1'b0, '0, '0);

        // Zero victim mask: completes with done pulse, writes nothing
        refill($urandom, 4'b0000, 0, 0, 7, NO, NO, 1'b0, 1'b0, '0, '0);

        // Flush while idle blocks acceptance
        miss_valid_i = 1'b1;
        flush_i      = 1'b1;
        #1;
        chk("idle_flush_ready", miss_ready_o, 0);
        tick();
        miss_valid_i = 1'b0;
        flush_i      = 1'b0;
        #1;
        chk("idle_flush_busy", busy_o, 0);

        // Flush in REQ suppresses the request even with ready high
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'h0000_8000;
        tick();
        miss_valid_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        flush_i         = 1'b1;
        #1;
        chk("req_flush_valid", mem_req_valid_o, 0);
        tick();
        mem_req_ready_i = 1'b0;
        flush_i         = 1'b0;
        #1;
        chk("req_flush_busy", busy_o, 0);
        chk("req_flush_count", n_reqs, exp_reqs);

        // Stray beat while idle sets the error; only reset clears it
        mem_rsp_valid_i = 1'b1;
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("stray_err", err_o, 1);
        tick();
        #1;
        chk("stray_err_sticky", err_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("stray_err_clear", err_o, 0);
        err_exp = 1'b0;

        // Randomized refills
        for (int k = 0; k < 16; k++) begin
            a = $urandom;
            r = int'($urandom_range(0, 4));
            w = (r == 4) ? 4'b0000 : 4'(1 << r);
            refill(a, w, int'($urandom_range(0, 3)), -1, 7, NO, NO, 1'b0, 1'b0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
